dac_burst_seq: RTL and testbench

DAC_BURST_SEQ -- requirements
Module: dac_burst_seq

---
 rtl/dac_burst_seq_pkg.sv | 27 ++
 rtl/sync_edge_det.sv | 27 ++
 rtl/dac_burst_seq.sv | 137 +++++++++++++
 tb/tb_dac_burst_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_burst_seq_pkg.sv
// Shared definitions for the DAC burst sequencer: default widths and the
// controller state encoding, kept alongside the DAC register map.
package dac_burst_seq_pkg;

  localparam int ADDR_W_DEF = 13;  // waveform RAM address width
  localparam int CNT_W_DEF  = 16;  // trigger-to-play delay counter width

  // Encodings are visible on o_state, so the values are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_DELAY = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic {
    TRIG_IMM  = 1'b0,  // leave ARM on the next cycle
    TRIG_SYNC = 1'b1   // leave ARM on a synchronized i_sync rising edge
  } trig_mode_e;

  // A burst is in progress while armed, delaying or playing.
  function automatic logic is_busy(input state_e s);
    return (s == ST_ARM) || (s == ST_DELAY) || (s == ST_PLAY);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Brings the external trigger into the i_clk domain and flags its rising
// edge as a single-cycle pulse.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_async,
  output logic o_rise
);

  logic sync1, sync2, sync3;

  // Two-flop synchronizer followed by one history stage for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= i_async;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign o_rise = sync2 & ~sync3;

endmodule

// File: rtl/dac_burst_seq.sv
// Burst sequencer that walks a window of the waveform RAM a programmable
// number of times, optionally waiting for an external sync edge and a
// delay before each pass.
module dac_burst_seq
  import dac_burst_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_sync,
  input  logic              i_trig_mode,
  input  logic [CNT_W-1:0]  i_delay,
  input  logic [ADDR_W-1:0] i_beg_addr,
  input  logic [ADDR_W-1:0] i_len,
  input  logic [7:0]        i_rep,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_vld,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sync_miss,
  output logic [2:0]        o_state
);

  state_e            state_q, state_d;
  trig_mode_e        mode_q;
  logic [CNT_W-1:0]  delay_q, dly_cnt_q;
  logic [ADDR_W-1:0] beg_q, len_q, smp_cnt_q;
  logic [7:0]        rep_q, rep_cnt_q;
  logic              sync_rise;
  logic              start_ok, pass_end, last_pass, emit;

  sync_edge_det u_sync (
    .i_clk   (i_clk),
    .i_clr   (i_clr),
    .i_async (i_sync),
    .o_rise  (sync_rise)
  );

  // Next-state decode; abort always wins over progress in a busy state.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    start_ok  = 1'b0;
    pass_end  = 1'b0;
    last_pass = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          start_ok = 1'b1;
          state_d  = (i_len == '0) ? ST_DONE : ST_ARM;
        end
      end
      ST_ARM: begin
        if (i_abort) state_d = ST_DONE;
        else if (mode_q == TRIG_IMM || sync_rise)
          state_d = (delay_q != '0) ? ST_DELAY : ST_PLAY;
      end
      ST_DELAY: begin
        if (i_abort) state_d = ST_DONE;
        else if (dly_cnt_q == '0) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (i_abort) state_d = ST_DONE;
        else if (smp_cnt_q == len_q - ADDR_W'(1)) begin
          pass_end  = 1'b1;
          last_pass = (rep_q != 8'd0) && (rep_cnt_q == 8'd1);
          if (last_pass)               state_d = ST_DONE;
          else if (mode_q == TRIG_SYNC) state_d = ST_ARM;
          else                          state_d = ST_PLAY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A sample is issued on every non-aborted PLAY cycle, one cycle later.
  assign emit = (state_q == ST_PLAY) && !i_abort;

  // State, latched burst configuration, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      state_q     <= ST_IDLE;
      mode_q      <= TRIG_IMM;
      delay_q     <= '0;
      beg_q       <= '0;
      len_q       <= '0;
      rep_q       <= '0;
      dly_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      o_ram_addr  <= '0;
      o_ram_vld   <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_sync_miss <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      o_busy    <= is_busy(state_d);
      o_done    <= (state_d == ST_DONE);
      o_ram_vld <= emit;

      if (start_ok) begin
        mode_q      <= trig_mode_e'(i_trig_mode);
        delay_q     <= i_delay;
        beg_q       <= i_beg_addr;
        len_q       <= i_len;
        rep_q       <= i_rep;
        rep_cnt_q   <= i_rep;
        smp_cnt_q   <= '0;
        o_sync_miss <= 1'b0;
      end else if (sync_rise && is_busy(state_q) && state_q != ST_ARM) begin
        o_sync_miss <= 1'b1;
      end

      if (state_q == ST_ARM && state_d == ST_DELAY)
        dly_cnt_q <= delay_q - CNT_W'(1);
      else if (state_q == ST_DELAY && dly_cnt_q != '0)
        dly_cnt_q <= dly_cnt_q - CNT_W'(1);

      if (emit) begin
        o_ram_addr <= beg_q + smp_cnt_q;
        smp_cnt_q  <= pass_end ? '0 : smp_cnt_q + ADDR_W'(1);
        if (pass_end && rep_q != 8'd0)
          rep_cnt_q <= rep_cnt_q - 8'd1;
      end
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_dac_burst_seq.sv
// Self-checking bench for dac_burst_seq: expected RAM addresses are queued
// when a burst is launched and consumed as o_ram_vld samples appear.
module tb_dac_burst_seq;

  localparam int ADDR_W = 13;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              clr, start, abort, sync, mode;
  logic [CNT_W-1:0]  delay;
  logic [ADDR_W-1:0] beg, len;
  logic [7:0]        rep;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_vld, busy, done, sync_miss;
  logic [2:0]        state;

  int checks = 0;
  int errors = 0;
  int cyc, first_vld, last_vld, n_vld, n_done;
  logic [ADDR_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  dac_burst_seq dut (
    .i_clk       (clk),
    .i_clr       (clr),
    .i_start     (start),
    .i_abort     (abort),
    .i_sync      (sync),
    .i_trig_mode (mode),
    .i_delay     (delay),
    .i_beg_addr  (beg),
    .i_len       (len),
    .i_rep       (rep),
    .o_ram_addr  (ram_addr),
    .o_ram_vld   (ram_vld),
    .o_busy      (busy),
    .o_done      (done),
    .o_sync_miss (sync_miss),
    .o_state     (state)
  );

  // Advance one cycle, sample on the falling edge, score any played sample.
  task automatic step();
    logic [ADDR_W-1:0] exp_addr;
    @(negedge clk);
    cyc++;
    if (ram_vld === 1'b1) begin
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      n_vld++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld: vld=1 addr=%0d at cycle %0d, required vld=0", ram_addr, cyc);
      end else begin
        exp_addr = exp_q.pop_front();
        if (ram_addr !== exp_addr) begin
          errors++;
          $display("FAIL ram_addr: got %0d, required %0d (cycle %0d)", ram_addr, exp_addr, cyc);
        end
      end
    end
    if (done === 1'b1) n_done++;
  endtask

  task automatic clear_stats();
    cyc = 0; first_vld = -1; last_vld = -1; n_vld = 0; n_done = 0;
  endtask

  task automatic configure(input logic m, input int d, input int b, input int l, input int r);
    mode  = m;
    delay = CNT_W'(d);
    beg   = ADDR_W'(b);
    len   = ADDR_W'(l);
    rep   = 8'(r);
  endtask

  // Model: each pass plays beg, beg+1, ... modulo the address space.
  task automatic push_pass(input int b, input int l, input int times);
    logic [ADDR_W-1:0] a;
    for (int t = 0; t < times; t++)
      for (int n = 0; n < l; n++) begin
        a = ADDR_W'(b) + ADDR_W'(n);
        exp_q.push_back(a);
      end
  endtask

  task automatic launch();
    clear_stats();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Run until o_done is seen, then one more cycle, which must be IDLE.
  task automatic run_burst(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) step();
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL burst_timeout: no o_done within %0d cycles", budget);
    end else begin
      step();
      if (state !== 3'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL end_idle: state=%0d busy=%0b, required state=0 busy=0", state, busy);
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; abort = 1'b0; sync = 1'b0;
    configure(1'b0, 0, 0, 0, 0);
    clear_stats();
    repeat (3) step();
    checks++;
    if ({ram_addr, ram_vld, busy, done, sync_miss} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d vld=%0b busy=%0b done=%0b miss=%0b, required all 0",
               ram_addr, ram_vld, busy, done, sync_miss);
    end
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d, required 0", state);
    end
    clr = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    configure(1'b0, 0, 100, 4, 2);
    push_pass(100, 4, 2);
    launch();
    run_burst(40);
    checks++;
    if (first_vld !== 3) begin
      errors++;
      $display("FAIL b2b_latency: first vld at cycle %0d, required 3", first_vld);
    end
    checks++;
    if (n_vld !== 8 || last_vld - first_vld + 1 !== 8) begin
      errors++;
      $display("FAIL b2b_contiguous: %0d samples over span %0d, required 8 over 8",
               n_vld, last_vld - first_vld + 1);
    end
    checks++;
    if (n_done !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_done: done pulses=%0d left=%0d, required 1 and 0", n_done, exp_q.size());
    end
  endtask

  task automatic test_sync_trigger();
    configure(1'b1, 5, 10, 3, 3);
    launch();
    repeat (4) step();
    checks++;
    if (state !== 3'd1 || n_vld !== 0) begin
      errors++;
      $display("FAIL arm_wait: state=%0d vld samples=%0d, required state=1 and 0", state, n_vld);
    end
    for (int p = 0; p < 3; p++) begin
      push_pass(10, 3, 1);
      clear_stats();
      sync = 1'b1;
      for (int i = 0; i < 24 && n_vld < 3; i++) begin
        step();
        if (cyc == 3) sync = 1'b0;
      end
      sync = 1'b0;
      checks++;
      if (first_vld !== 9 || n_vld !== 3) begin
        errors++;
        $display("FAIL sync_latency: pass %0d first vld %0d samples %0d, required 9 and 3",
                 p, first_vld, n_vld);
      end
      if (p < 2) begin
        repeat (3) step();
        checks++;
        if (state !== 3'd1 || n_vld !== 3) begin
          errors++;
          $display("FAIL rearm: pass %0d state=%0d samples=%0d, required state=1 samples=3",
                   p, state, n_vld);
        end
      end else begin
        run_burst(10);
      end
    end
    checks++;
    if (sync_miss !== 1'b0) begin
      errors++;
      $display("FAIL no_miss: sync_miss=%0b, required 0", sync_miss);
    end
  endtask

  task automatic test_wrap();
    configure(1'b0, 0, 8190, 4, 1);
    push_pass(8190, 4, 1);
    launch();
    run_burst(30);
    checks++;
    if (n_vld !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL wrap_count: samples=%0d left=%0d, required 4 and 0", n_vld, exp_q.size());
    end
  endtask

  task automatic test_abort_infinite();
    configure(1'b0, 2, 50, 3, 0);
    push_pass(50, 3, 4);
    launch();
    for (int i = 0; i < 40 && n_vld < 7; i++) step();
    checks++;
    if (n_vld !== 7 || last_vld - first_vld + 1 !== 7) begin
      errors++;
      $display("FAIL infinite_play: %0d samples over span %0d, required 7 over 7",
               n_vld, last_vld - first_vld + 1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (ram_vld !== 1'b0 || done !== 1'b1 || state !== 3'd4) begin
      errors++;
      $display("FAIL abort_stop: vld=%0b done=%0b state=%0d, required 0 1 4", ram_vld, done, state);
    end
    checks++;
    if (ram_addr !== 13'd50) begin
      errors++;
      $display("FAIL abort_hold: addr=%0d, required 50", ram_addr);
    end
    step();
    checks++;
    if (state !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: state=%0d done=%0b, required 0 0", state, done);
    end
    exp_q.delete();
  endtask

  task automatic test_sync_miss();
    configure(1'b0, 0, 200, 20, 1);
    push_pass(200, 20, 1);
    launch();
    for (int i = 0; i < 10 && n_vld < 2; i++) step();
    sync = 1'b1;
    repeat (2) step();
    sync = 1'b0;
    run_burst(60);
    checks++;
    if (sync_miss !== 1'b1) begin
      errors++;
      $display("FAIL miss_set: sync_miss=%0b, required 1", sync_miss);
    end
    checks++;
    if (n_vld !== 20 || last_vld - first_vld + 1 !== 20 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL miss_play: %0d samples span %0d left %0d, required 20 20 0",
               n_vld, last_vld - first_vld + 1, exp_q.size());
    end
    configure(1'b0, 0, 300, 2, 1);
    push_pass(300, 2, 1);
    launch();
    checks++;
    if (sync_miss !== 1'b0) begin
      errors++;
      $display("FAIL miss_clear: sync_miss=%0b after start, required 0", sync_miss);
    end
    run_burst(20);
  endtask

  task automatic test_clr_delay();
    configure(1'b0, 50, 7, 4, 1);
    launch();
    repeat (3) step();
    checks++;
    if (state !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL in_delay: state=%0d busy=%0b, required 2 1", state, busy);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if ({ram_addr, ram_vld, busy, done, sync_miss, state} !== '0) begin
      errors++;
      $display("FAIL clr_outputs: addr=%0d vld=%0b busy=%0b done=%0b miss=%0b state=%0d, required all 0",
               ram_addr, ram_vld, busy, done, sync_miss, state);
    end
    repeat (5) step();
    checks++;
    if (n_vld !== 0 || state !== 3'd0) begin
      errors++;
      $display("FAIL clr_quiet: samples=%0d state=%0d, required 0 0", n_vld, state);
    end
  endtask

  task automatic test_len_zero();
    configure(1'b0, 0, 5, 0, 1);
    launch();
    checks++;
    if (state !== 3'd4 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_done: state=%0d done=%0b busy=%0b, required 4 1 0", state, done, busy);
    end
    run_burst(10);
    checks++;
    if (n_vld !== 0 || n_done !== 1) begin
      errors++;
      $display("FAIL len0_count: samples=%0d done pulses=%0d, required 0 1", n_vld, n_done);
    end
  endtask

  task automatic test_abort_start();
    configure(1'b0, 0, 5, 4, 1);
    clear_stats();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    repeat (3) step();
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || n_vld !== 0 || n_done !== 0) begin
      errors++;
      $display("FAIL abort_wins: state=%0d busy=%0b samples=%0d done=%0d, required all 0",
               state, busy, n_vld, n_done);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sync_trigger();
    test_wrap();
    test_abort_infinite();
    test_sync_miss();
    test_clr_delay();
    test_len_zero();
    test_abort_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
